// File: rtl/pcileech_tlps128_tx_scheduler_if.sv
// 128-bit TLP stream interface shared by the TX scheduler and its sources/sink.
// Latency: n/a (wires only).
// Backpressure: tready flows sink->source; has_data advertises a pending packet.
//
// Signals:
//   tdata    [127:0]  TLP payload beat
//   tkeepdw  [3:0]    valid dword mask
//   tvalid            beat valid
//   tlast             final beat of a TLP
//   tuser    [8:0]    sideband
//   tready            consumer pull; sources answer with 1-clk read latency
//   has_data          source holds at least one pending packet
interface IfAXIS128;
   logic [127:0] tdata;
   logic [3:0]   tkeepdw;
   logic         tvalid;
   logic         tlast;
   logic [8:0]   tuser;
   logic         tready;
   logic         has_data;

   modport source (output tdata, tkeepdw, tvalid, tlast, tuser, has_data, input tready);
   modport sink   (input tdata, tkeepdw, tvalid, tlast, tuser, has_data, output tready);
endinterface

// File: rtl/pcileech_tlps128_tx_scheduler.sv
// Packet-atomic 4:1 TX TLP scheduler: fixed priority in1 > in2 > bus-master RR (in3/in4) with aging.
// Latency: data path is combinational from the granted source; the grant register follows id_d every cycle.
// Backpressure: tlps_out.tready is forwarded only to the source selected by id_d; others see tready = 0.
//
// Ports:
//   clk_pcie           PCIe user clock
//   rst                synchronous active-high reset
//   bus_master_enable  gates eligibility of in3/in4
//   tlps_out           scheduled TX stream to PCIe core
//   tlps_in1..in4      config responses, BAR completions, host-FIFO TLPs, static TLPs
//   grant_id  [2:0]    currently granted source, 0 = idle
//   starve_evt         one-cycle pulse after an aging override grant
module pcileech_tlps128_tx_scheduler #(
   parameter int AGE_MAX = 8
) (
   input  logic       clk_pcie,
   input  logic       rst,
   input  logic       bus_master_enable,
   IfAXIS128.source   tlps_out,
   IfAXIS128.sink     tlps_in1,
   IfAXIS128.sink     tlps_in2,
   IfAXIS128.sink     tlps_in3,
   IfAXIS128.sink     tlps_in4,
   output logic [2:0] grant_id,
   output logic       starve_evt
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_G1   = 3'd1,
      ST_G2   = 3'd2,
      ST_G3   = 3'd3,
      ST_G4   = 3'd4
   } id_t;

   localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

   id_t        id_q, id_d;
   id_t        newsel;
   id_t        rr_pick;
   logic       rr_q, rr_d;
   logic [3:0] age_q, age_d;
   logic       starve_q, starve_d;

   logic el1, el2, el3, el4;
   logic bm_elig;
   logic override;
   logic pkt_end;
   logic reselect;
   logic new_grant;
   logic bm_grant;

   // ---------------------------------------------------------------
   // Eligibility
   // ---------------------------------------------------------------
   assign el1     = tlps_in1.has_data;
   assign el2     = tlps_in2.has_data;
   assign el3     = tlps_in3.has_data & bus_master_enable;
   assign el4     = tlps_in4.has_data & bus_master_enable;
   assign bm_elig = el3 | el4;

   assign tlps_out.has_data = el1 | el2 | el3 | el4;

   // Bus-master round robin: rr = 0 prefers in3, rr = 1 prefers in4.
   always_comb begin
      rr_pick = ST_IDLE;
      if (!rr_q) begin
         if (el3)      rr_pick = ST_G3;
         else if (el4) rr_pick = ST_G4;
      end else begin
         if (el4)      rr_pick = ST_G4;
         else if (el3) rr_pick = ST_G3;
      end
   end

   // Aging override lets a waiting bus-master source jump ahead of in1/in2.
   assign override = (age_q == AGE_LIM) & bm_elig;

   always_comb begin
      newsel = ST_IDLE;
      if (override)  newsel = rr_pick;
      else if (el1)  newsel = ST_G1;
      else if (el2)  newsel = ST_G2;
      else           newsel = rr_pick;
   end

   // ---------------------------------------------------------------
   // Output mux, driven from the registered grant
   // ---------------------------------------------------------------
   always_comb begin
      tlps_out.tdata   = '0;
      tlps_out.tkeepdw = '0;
      tlps_out.tvalid  = 1'b0;
      tlps_out.tlast   = 1'b0;
      tlps_out.tuser   = '0;
      case (id_q)
         ST_G1: begin
            tlps_out.tdata   = tlps_in1.tdata;
            tlps_out.tkeepdw = tlps_in1.tkeepdw;
            tlps_out.tvalid  = tlps_in1.tvalid;
            tlps_out.tlast   = tlps_in1.tlast;
            tlps_out.tuser   = tlps_in1.tuser;
         end
         ST_G2: begin
            tlps_out.tdata   = tlps_in2.tdata;
            tlps_out.tkeepdw = tlps_in2.tkeepdw;
            tlps_out.tvalid  = tlps_in2.tvalid;
            tlps_out.tlast   = tlps_in2.tlast;
            tlps_out.tuser   = tlps_in2.tuser;
         end
         ST_G3: begin
            tlps_out.tdata   = tlps_in3.tdata;
            tlps_out.tkeepdw = tlps_in3.tkeepdw;
            tlps_out.tvalid  = tlps_in3.tvalid;
            tlps_out.tlast   = tlps_in3.tlast;
            tlps_out.tuser   = tlps_in3.tuser;
         end
         ST_G4: begin
            tlps_out.tdata   = tlps_in4.tdata;
            tlps_out.tkeepdw = tlps_in4.tkeepdw;
            tlps_out.tvalid  = tlps_in4.tvalid;
            tlps_out.tlast   = tlps_in4.tlast;
            tlps_out.tuser   = tlps_in4.tuser;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Grant sequencing: re-arbitrate when idle or on the last beat so
   // back-to-back packets need no bubble; otherwise hold the grant
   // until tlast regardless of eligibility changes.
   // ---------------------------------------------------------------
   assign pkt_end   = tlps_out.tvalid & tlps_out.tlast;
   assign reselect  = (id_q == ST_IDLE) | pkt_end;
   assign id_d      = reselect ? newsel : id_q;
   assign new_grant = reselect & (newsel != ST_IDLE);
   assign bm_grant  = new_grant & ((newsel == ST_G3) | (newsel == ST_G4));

   // Sources see tready one cycle ahead of their data appearing on
   // tlps_out. Held low during reset so no source pops a beat.
   assign tlps_in1.tready = ~rst & tlps_out.tready & (id_d == ST_G1);
   assign tlps_in2.tready = ~rst & tlps_out.tready & (id_d == ST_G2);
   assign tlps_in3.tready = ~rst & tlps_out.tready & (id_d == ST_G3);
   assign tlps_in4.tready = ~rst & tlps_out.tready & (id_d == ST_G4);

   always_comb begin
      rr_d = rr_q;
      if (bm_grant) rr_d = (newsel == ST_G3);   // point away from the winner
   end

   always_comb begin
      age_d = age_q;
      if (!bm_elig)
         age_d = '0;
      else if (bm_grant)
         age_d = '0;
      else if (new_grant && (age_q != AGE_LIM))
         age_d = age_q + 4'd1;                  // in1/in2 won while bus master waited
   end

   assign starve_d = new_grant & override & (el1 | el2);

   always_ff @(posedge clk_pcie) begin
      if (rst) begin
         id_q     <= ST_IDLE;
         rr_q     <= 1'b0;
         age_q    <= '0;
         starve_q <= 1'b0;
      end else begin
         id_q     <= id_d;
         rr_q     <= rr_d;
         age_q    <= age_d;
         starve_q <= starve_d;
      end
   end

   assign grant_id   = id_q;
   assign starve_evt = starve_q;

endmodule

// File: tb/tb_pcileech_tlps128_tx_scheduler.sv
// Directed self-checking bench for pcileech_tlps128_tx_scheduler.
// Sources are modelled as FIFOs with 1-clk read latency: a tready seen
// before an edge presents the next queued beat just after that edge.
module tb_pcileech_tlps128_tx_scheduler;

   logic clk_pcie = 1'b0;
   always #5 clk_pcie = ~clk_pcie;

   logic       rst;
   logic       bus_master_enable;
   logic       out_rdy;
   logic [2:0] grant_id;
   logic       starve_evt;

   IfAXIS128 tlps_out ();
   IfAXIS128 tlps_in1 ();
   IfAXIS128 tlps_in2 ();
   IfAXIS128 tlps_in3 ();
   IfAXIS128 tlps_in4 ();

   pcileech_tlps128_tx_scheduler #(.AGE_MAX(8)) dut (
      .clk_pcie          (clk_pcie),
      .rst               (rst),
      .bus_master_enable (bus_master_enable),
      .tlps_out          (tlps_out),
      .tlps_in1          (tlps_in1),
      .tlps_in2          (tlps_in2),
      .tlps_in3          (tlps_in3),
      .tlps_in4          (tlps_in4),
      .grant_id          (grant_id),
      .starve_evt        (starve_evt)
   );

   // ---------------- source model storage ----------------
   logic [127:0] mem_dat  [1:4][0:63];
   logic         mem_last [1:4][0:63];
   int           wr_ptr   [1:4];
   int           rd_ptr   [1:4];
   logic [127:0] s_dat    [1:4];
   logic         s_vld    [1:4];
   logic         s_last   [1:4];

   assign tlps_out.tready = out_rdy;

   assign tlps_in1.tdata    = s_dat[1];
   assign tlps_in1.tvalid   = s_vld[1];
   assign tlps_in1.tlast    = s_last[1];
   assign tlps_in1.tkeepdw  = 4'hF;
   assign tlps_in1.tuser    = 9'd1;
   assign tlps_in1.has_data = (wr_ptr[1] != rd_ptr[1]);

   assign tlps_in2.tdata    = s_dat[2];
   assign tlps_in2.tvalid   = s_vld[2];
   assign tlps_in2.tlast    = s_last[2];
   assign tlps_in2.tkeepdw  = 4'hF;
   assign tlps_in2.tuser    = 9'd2;
   assign tlps_in2.has_data = (wr_ptr[2] != rd_ptr[2]);

   assign tlps_in3.tdata    = s_dat[3];
   assign tlps_in3.tvalid   = s_vld[3];
   assign tlps_in3.tlast    = s_last[3];
   assign tlps_in3.tkeepdw  = 4'hF;
   assign tlps_in3.tuser    = 9'd3;
   assign tlps_in3.has_data = (wr_ptr[3] != rd_ptr[3]);

   assign tlps_in4.tdata    = s_dat[4];
   assign tlps_in4.tvalid   = s_vld[4];
   assign tlps_in4.tlast    = s_last[4];
   assign tlps_in4.tkeepdw  = 4'hF;
   assign tlps_in4.tuser    = 9'd4;
   assign tlps_in4.has_data = (wr_ptr[4] != rd_ptr[4]);

   // ---------------- expected sequences ----------------
   int seq1  [4]  = '{1, 2, 3, 0};
   int seq2  [9]  = '{4, 4, 3, 3, 4, 4, 3, 3, 0};
   int last2 [9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
   int seq3  [13] = '{2, 2, 2, 2, 2, 2, 2, 2, 4, 2, 2, 4, 0};
   int seq4  [6]  = '{3, 3, 2, 2, 2, 0};
   int idx4  [6]  = '{7, 8, 11, 12, 13, 0};

   int n_pass = 0;
   int n_fail = 0;

   function automatic logic [127:0] beat(input int s, input int idx);
      return {8'(s), 120'(idx)};
   endfunction

   task automatic push_pkt(input int s, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         mem_dat[s][wr_ptr[s]]  = beat(s, wr_ptr[s]);
         mem_last[s][wr_ptr[s]] = (b == nbeats - 1);
         wr_ptr[s]++;
      end
   endtask

   // One clock: sample tready mid-cycle, then let each pulled source
   // present its next beat shortly after the edge.
   task automatic tick();
      logic r [1:4];
      @(negedge clk_pcie);
      r[1] = tlps_in1.tready;
      r[2] = tlps_in2.tready;
      r[3] = tlps_in3.tready;
      r[4] = tlps_in4.tready;
      @(posedge clk_pcie);
      #1;
      for (int s = 1; s <= 4; s++) begin
         if (r[s]) begin
            if (wr_ptr[s] != rd_ptr[s]) begin
               s_dat[s]  = mem_dat[s][rd_ptr[s]];
               s_last[s] = mem_last[s][rd_ptr[s]];
               s_vld[s]  = 1'b1;
               rd_ptr[s]++;
            end else begin
               s_vld[s]  = 1'b0;
               s_last[s] = 1'b0;
            end
         end
      end
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst               = 1'b1;
      bus_master_enable = 1'b1;
      out_rdy           = 1'b1;
      for (int s = 1; s <= 4; s++) begin
         wr_ptr[s] = 0;
         rd_ptr[s] = 0;
         s_dat[s]  = '0;
         s_vld[s]  = 1'b0;
         s_last[s] = 1'b0;
      end

      // ---- reset state, with traffic already pending ----
      push_pkt(1, 1);
      push_pkt(2, 1);
      push_pkt(3, 1);
      tick();
      tick();
      check("rst_grant",    grant_id, 0);
      check("rst_tvalid",   tlps_out.tvalid, 0);
      check("rst_tdata",    tlps_out.tdata, 0);
      check("rst_starve",   starve_evt, 0);
      check("rst_tready1",  tlps_in1.tready, 0);
      check("rst_has_data", tlps_out.has_data, 1);

      // ---- scenario 1: in1, in2, in3 single beats back to back ----
      rst = 1'b0;
      #1;
      check("s1_tready1_pre", tlps_in1.tready, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("s1_grant", grant_id, seq1[i]);
         check("s1_tdata", tlps_out.tdata, (seq1[i] == 0) ? 128'd0 : beat(seq1[i], 0));
         check("s1_tuser", tlps_out.tuser, seq1[i]);
      end
      check("s1_idle_has_data", tlps_out.has_data, 0);

      // ---- scenario 2: in3/in4 2-beat packets alternate (rr left at in4) ----
      push_pkt(3, 2);
      push_pkt(4, 2);
      push_pkt(3, 2);
      push_pkt(4, 2);
      for (int i = 0; i < 9; i++) begin
         tick();
         check("s2_grant", grant_id, seq2[i]);
         check("s2_tlast", tlps_out.tlast, last2[i]);
      end

      // ---- scenario 3: aging override after eight in2 grants ----
      for (int i = 0; i < 10; i++) push_pkt(2, 1);
      push_pkt(4, 1);
      push_pkt(4, 1);
      for (int i = 0; i < 13; i++) begin
         tick();
         check("s3_grant",  grant_id, seq3[i]);
         check("s3_starve", starve_evt, (i == 8) ? 1 : 0);
      end

      // ---- scenario 4: bus_master_enable drops mid in3 packet ----
      push_pkt(3, 4);
      push_pkt(4, 1);
      tick();
      check("s4_b1_grant", grant_id, 3);
      check("s4_b1_tdata", tlps_out.tdata, beat(3, 5));
      tick();
      check("s4_b2_tdata", tlps_out.tdata, beat(3, 6));
      bus_master_enable = 1'b0;
      push_pkt(2, 1);
      push_pkt(2, 1);
      push_pkt(2, 1);
      #1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("s4_grant", grant_id, seq4[i]);
         check("s4_tdata", tlps_out.tdata, (seq4[i] == 0) ? 128'd0 : beat(seq4[i], idx4[i]));
      end
      check("s4_masked_has_data", tlps_out.has_data, 0);
      check("s4_masked_tready4",  tlps_in4.tready, 0);
      bus_master_enable = 1'b1;
      #1;
      tick();
      check("s4_bme_back_grant", grant_id, 4);
      tick();
      check("s4_end_grant", grant_id, 0);

      // ---- scenario 5: output stalls for 5 cycles mid in1 packet ----
      push_pkt(1, 4);
      tick();
      check("s5_b1_tdata", tlps_out.tdata, beat(1, 1));
      tick();
      check("s5_b2_tdata", tlps_out.tdata, beat(1, 2));
      out_rdy = 1'b0;
      #1;
      check("s5_stall_tready1", tlps_in1.tready, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("s5_stall_grant",  grant_id, 1);
         check("s5_stall_tvalid", tlps_out.tvalid, 1);
         check("s5_stall_tdata",  tlps_out.tdata, beat(1, 2));
      end
      out_rdy = 1'b1;
      #1;
      check("s5_resume_tready1", tlps_in1.tready, 1);
      tick();
      check("s5_b3_tdata", tlps_out.tdata, beat(1, 3));
      tick();
      check("s5_b4_tdata", tlps_out.tdata, beat(1, 4));
      check("s5_b4_tlast", tlps_out.tlast, 1);
      tick();
      check("s5_end_grant", grant_id, 0);

      // ---- scenario 6: reset mid in4 packet, then in3 wins with rr = 0 ----
      push_pkt(4, 4);
      tick();
      check("s6_b1_grant", grant_id, 4);
      check("s6_b1_tdata", tlps_out.tdata, beat(4, 7));
      tick();
      check("s6_b2_tdata", tlps_out.tdata, beat(4, 8));
      rst = 1'b1;
      push_pkt(3, 1);
      #1;
      check("s6_rst_tready4", tlps_in4.tready, 0);
      check("s6_rst_tready3", tlps_in3.tready, 0);
      tick();
      check("s6_rst_grant",  grant_id, 0);
      check("s6_rst_tvalid", tlps_out.tvalid, 0);
      check("s6_rst_starve", starve_evt, 0);
      rst = 1'b0;
      #1;
      check("s6_rel_tready3", tlps_in3.tready, 1);
      check("s6_rel_tready4", tlps_in4.tready, 0);
      tick();
      check("s6_first_grant", grant_id, 3);
      check("s6_first_tdata", tlps_out.tdata, beat(3, 9));
      tick();
      check("s6_second_grant", grant_id, 4);
      check("s6_second_tdata", tlps_out.tdata, beat(4, 9));

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
